seq_gen_tx: RTL and testbench

SEQ_GEN_TX -- requirements
Module: seq_gen_tx

---
 rtl/seq_gen_tx.sv | 147 ++++++++++++++
 tb/tb_seq_gen_tx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seq_gen_tx.sv
// Framed serial bit generator: optional 11110 preamble, MSB-first payload with a 0 stuffed
// after every run of three 1s, then GAP_CYCLES zero bits. Preamble gated by SEQ_GEN_TX_PREAMBLE_EN.
module seq_gen_tx #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              x,
    output logic              busy,
    output logic              done
);
    localparam int IW = $clog2(DATA_W) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
`ifdef SEQ_GEN_TX_PREAMBLE_EN
    localparam logic [2:0] S_PRE   = 3'd1;
`endif
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STUFF = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        run_q, run_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              x_q, x_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              stuff;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        data_d  = data_q;
        stuff   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    data_d = data;
                    run_d  = 2'd0;
                    idx_d  = IW'(DATA_W - 1);
                    cnt_d  = 4'd0;
`ifdef SEQ_GEN_TX_PREAMBLE_EN
                    state_d = S_PRE;
`else
                    state_d = S_DATA;
`endif
                end
            end
`ifdef SEQ_GEN_TX_PREAMBLE_EN
            S_PRE: begin
                if (cnt_q == 4'd4) begin
                    state_d = S_DATA;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
`endif
            S_DATA: begin
                // data_q always holds the bit on x at its MSB; consume it on leaving DATA.
                data_d = data_q << 1;
                stuff  = data_q[DATA_W-1] && (run_q == 2'd2);
                if (stuff || !data_q[DATA_W-1]) begin
                    run_d = 2'd0;
                end else begin
                    run_d = run_q + 2'd1;
                end
                if (stuff) begin
                    state_d = S_STUFF;
                end else if (idx_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = 4'd0;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            S_STUFF: begin
                if (idx_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = S_DATA;
                    idx_d   = idx_q - IW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == 4'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                cnt_d   = 4'd0;
                run_d   = 2'd0;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        x_d = 1'b0;
        case (state_d)
`ifdef SEQ_GEN_TX_PREAMBLE_EN
            S_PRE:   x_d = (cnt_d != 4'd4);
`endif
            S_DATA:  x_d = data_d[DATA_W-1];
            default: x_d = 1'b0;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_GAP) && (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= 4'd0;
            run_q   <= 2'd0;
            data_q  <= '0;
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            data_q  <= data_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x    = x_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_seq_gen_tx.sv
// Bench for seq_gen_tx: frame-level bit-queue reference model with an 11110 detector on x.
// Works with or without SEQ_GEN_TX_PREAMBLE_EN defined.
module tb_seq_gen_tx;
    localparam int DATA_W = 8;
    localparam int GAP    = 2;
`ifdef SEQ_GEN_TX_PREAMBLE_EN
    localparam int P = 5;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0;
    logic reset, start;
    logic [DATA_W-1:0] data;
    logic x, busy, done;

    seq_gen_tx #(.DATA_W(DATA_W), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .start(start), .data(data),
        .x(x), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: q holds the remaining bits of the current frame, front = bit on x now.
    bit   q[$];
    bit   frm[$];
    logic ex, eb, ed;
    int   ndone = 0;
    logic [4:0] hist = '0;
    int   zcnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void build_frame(input logic [DATA_W-1:0] d);
        int run;
        frm.delete();
        if (P > 0) begin
            frm.push_back(1); frm.push_back(1); frm.push_back(1); frm.push_back(1); frm.push_back(0);
        end
        run = 0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            frm.push_back(d[i]);
            if (d[i]) begin
                run++;
                if (run == 3) begin
                    frm.push_back(0);
                    run = 0;
                end
            end else begin
                run = 0;
            end
        end
        for (int i = 0; i < GAP; i++) frm.push_back(0);
    endfunction

    task automatic model_step();
        if (reset) begin
            q.delete();
            ex = 0; eb = 0; ed = 0;
            hist = '0; zcnt = 0;
        end else if (q.size() == 0) begin
            ed = 0;
            if (start) begin
                build_frame(data);
                q = frm;
                ex = q[0]; eb = 1;
            end else begin
                ex = 0; eb = 0;
            end
        end else begin
            void'(q.pop_front());
            if (q.size() > 0) begin
                ex = q[0]; eb = 1; ed = 0;
            end else begin
                ex = 0; eb = 0; ed = 1;
                ndone++;
            end
        end
    endtask

    // One clock: advance the model on the edge, then compare just after it.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("x", 64'(x), 64'(ex));
        check("busy", 64'(busy), 64'(eb));
        check("done", 64'(done), 64'(ed));
        hist = {hist[3:0], x};
        if (hist == 5'b11110) zcnt++;
        if (ed) begin
            check("z_per_frame", 64'(zcnt), 64'((P > 0) ? 1 : 0));
            zcnt = 0;
        end
    endtask

    task automatic run_frame(input logic [DATA_W-1:0] d, input int plen,
                             input logic [15:0] plit, input string name);
        int len, bc;
        logic [63:0] exp_bits, mbits, cap;
        len = P + plen;
        exp_bits = (P > 0) ? ((64'h1E << plen) | 64'(plit)) : 64'(plit);
        build_frame(d);
        mbits = '0;
        foreach (frm[i]) mbits = {mbits[62:0], frm[i]};
        check({name, "_model_len"}, 64'(frm.size()), 64'(len));
        check({name, "_model_bits"}, mbits, exp_bits);
        start = 1; data = d;
        tick();
        start = 0;
        cap = 64'(x);
        bc = int'(busy);
        for (int i = 1; i < len; i++) begin
            tick();
            cap = {cap[62:0], x};
            bc += int'(busy);
        end
        tick();
        check({name, "_bits"}, cap, exp_bits);
        check({name, "_busy_cycles"}, 64'(bc), 64'(len));
        check({name, "_done_pulse"}, 64'(done), 64'd1);
        tick();
        check({name, "_done_once"}, 64'(done), 64'd0);
    endtask

    initial begin
        int base, cyc;
        reset = 1; start = 1; data = 8'hFF;
        repeat (3) tick();
        check("reset_x", 64'(x), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        reset = 0; start = 0;
        repeat (2) tick();

        run_frame(8'hA5, 10, 16'b1010010100, "a5");
        run_frame(8'hFF, 12, 16'b111011101100, "ff");
        run_frame(8'hE0, 11, 16'b11100000000, "e0");
        run_frame(8'h00, 10, 16'b0000000000, "zero");

        // Held start: frames run back to back, restarting in each done cycle.
        base = ndone; cyc = 0;
        start = 1; data = 8'h00;
        while (ndone < base + 3 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("b2b_frames", 64'(ndone - base), 64'd3);
        start = 0;
        repeat (GAP + P + 12) tick();

        // Reset landing on the third payload bit aborts the frame.
        start = 1; data = 8'hFF;
        tick();
        start = 0;
        repeat (P + 2) tick();
        check("abort_pre_x", 64'(x), 64'd1);
        reset = 1;
        tick();
        check("abort_x", 64'(x), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        reset = 0;
        base = ndone;
        repeat (20) tick();
        check("abort_no_done", 64'(ndone - base), 64'd0);
        run_frame(8'hA5, 10, 16'b1010010100, "after_abort");

        // Random payloads with random start requests, including during busy.
        base = ndone; cyc = 0;
        while (ndone < base + 100 && cyc < 6000) begin
            start = ($urandom_range(0, 2) == 0);
            data  = 8'($urandom);
            tick();
            cyc++;
        end
        check("rand_frames", 64'(ndone - base), 64'd100);
        start = 0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
